// File: rtl/rl_ram_rsp_fifo.sv
// Response buffer for the 1RW RAM initiator: DEPTH x Width FIFO with occupancy count.
// Storage is not reset; only pointers and count are.
module rl_ram_rsp_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [Width-1:0]  push_data_i,
  input  logic              pop_i,
  output logic [Width-1:0]  data_o,
  output logic [CntW-1:0]   count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             pop;

  assign pop = pop_i & (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + PtrW'(1);
    if (pop)    rptr_d = rptr_q + PtrW'(1);
    unique case ({push_i, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= push_data_i;
  end

  // Empty buffer presents zero rather than stale storage.
  assign data_o  = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign count_o = count_q;

  push_not_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_i |-> (count_q < CntW'(Depth)));

endmodule

// File: rtl/rl_ram_1rw_initiator.sv
// Valid/ready initiator for a 1RW RAM with registered read data; read credits
// bound outstanding reads to the response buffer depth.
module rl_ram_1rw_initiator #(
  parameter int unsigned ABITS = 10,
  parameter int unsigned DBITS = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned BBITS = (DBITS + 7) / 8,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             rst_ni,
  input  logic             clk_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [ABITS-1:0] req_addr_i,
  input  logic [BBITS-1:0] req_be_i,
  input  logic [DBITS-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DBITS-1:0] rsp_rdata_o,
  output logic [ABITS-1:0] ram_addr_o,
  output logic             ram_we_o,
  output logic [BBITS-1:0] ram_be_o,
  output logic [DBITS-1:0] ram_din_o,
  input  logic [DBITS-1:0] ram_dout_i,
  output logic [CW-1:0]    rd_outstanding_o
);

  logic          rd_pending_q, rd_pending_d;
  logic          accept;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;

  // Credits count the read in flight to the RAM as well as buffered data.
  assign outstanding = count + CW'(rd_pending_q);
  assign req_ready_o = outstanding < CW'(DEPTH);
  assign accept      = req_valid_i & req_ready_o;

  assign ram_addr_o = req_addr_i;
  assign ram_be_o   = req_be_i;
  assign ram_din_o  = req_wdata_i;
  assign ram_we_o   = accept & req_we_i;

  assign rd_pending_d = accept & ~req_we_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_pending_q <= 1'b0;
    else         rd_pending_q <= rd_pending_d;
  end

  assign rsp_valid_o      = count != '0;
  assign rd_outstanding_o = outstanding;

  rl_ram_rsp_fifo #(
    .Depth (DEPTH),
    .Width (DBITS)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (rd_pending_q),
    .push_data_i (ram_dout_i),
    .pop_i       (rsp_valid_o & rsp_ready_i),
    .data_o      (rsp_rdata_o),
    .count_o     (count)
  );

endmodule
